ripple_carry_adder: RTL and testbench

RIPPLE_CARRY_ADDER -- requirements
Module: ripple_carry_adder

---
 rtl/rca_pkg.sv | 7 +
 rtl/ripple_carry_adder_full_adder.sv | 16 +
 rtl/ripple_carry_adder.sv | 51 +++++
 tb/tb_ripple_carry_adder.sv | 125 ++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared constants for the ripple carry adder and its bench.
package rca_pkg;

   // Operand width used when no override is given.
   localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// Single-bit full adder, the building block of the ripple chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   // Sum is the parity of the three inputs; carry is their majority.
   always_comb begin
      s    = a ^ b ^ cin;
      cout = (a & b) | (a & cin) | (b & cin);
   end

endmodule

// File: rtl/ripple_carry_adder.sv
// Ripple carry adder with one cycle of registered latency.
// Each bit's carry feeds the next bit directly, with no lookahead.
module ripple_carry_adder
   import rca_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             out_valid
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_comb;

   assign carry[0] = cin;

   // One full adder per bit, each taking the previous bit's carry.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (carry[i]),
         .s    (sum_comb[i]),
         .cout (carry[i+1])
      );
   end

   // Capture the result only on valid cycles so idle inputs never reach the
   // outputs; out_valid simply trails in_valid by one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum       <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum  <= sum_comb;
            cout <= carry[WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Directed bench for ripple_carry_adder at the default width.
module tb_ripple_carry_adder;
   import rca_pkg::*;

   localparam int W = DEFAULT_WIDTH;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic [W-1:0] sum;
   logic         cout;
   logic         out_valid;

   int compared;
   int mismatched;

   ripple_carry_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sum       (sum),
      .cout      (cout),
      .out_valid (out_valid)
   );

   // Free-running clock with a 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one set of inputs; they stay in place until the next call.
   task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic vc, input logic vv);
      a        = va;
      b        = vb;
      cin      = vc;
      in_valid = vv;
   endtask

   // Count one comparison and report it if the values disagree.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge, then compare all three outputs.
   task automatic expectResult(input string tag, input logic [W-1:0] es,
                               input logic ec, input logic ev);
      @(posedge clk);
      #1;
      checkOutput({tag, ".sum"}, 32'(sum), 32'(es));
      checkOutput({tag, ".cout"}, 32'(cout), 32'(ec));
      checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
   endtask

   // Main directed sequence.
   initial begin
      logic [W-1:0] ra, rb;
      logic         rc;
      logic [W:0]   full;

      compared   = 0;
      mismatched = 0;
      rst_n      = 1'b0;
      applyStimulus(16'hAAAA, 16'h5555, 1'b1, 1'b1);
      expectResult("reset0", 16'h0000, 1'b0, 1'b0);
      expectResult("reset1", 16'h0000, 1'b0, 1'b0);
      rst_n = 1'b1;

      applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b1);
      expectResult("basic", 16'h5555, 1'b0, 1'b1);
      applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b1);
      expectResult("ripple", 16'h0000, 1'b1, 1'b1);
      applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
      expectResult("allones", 16'hFFFF, 1'b1, 1'b1);
      applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b1);
      expectResult("zeros", 16'h0000, 1'b0, 1'b1);
      applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b1);
      expectResult("msbcarry", 16'h0000, 1'b1, 1'b1);

      for (int i = 0; i < 20; i++) begin
         ra   = W'($urandom_range(0, 65535));
         rb   = W'($urandom_range(0, 65535));
         rc   = 1'($urandom_range(0, 1));
         full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         applyStimulus(ra, rb, rc, 1'b1);
         expectResult($sformatf("rand%0d", i), full[W-1:0], full[W], 1'b1);
      end

      applyStimulus(16'h7777, 16'h8888, 1'b1, 1'b1);
      expectResult("prereset", 16'h0000, 1'b1, 1'b1);
      rst_n = 1'b0;
      applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b1);
      expectResult("midreset", 16'h0000, 1'b0, 1'b0);
      rst_n = 1'b1;
      applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
      expectResult("postreset", 16'h0000, 1'b0, 1'b0);

      applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b1);
      expectResult("holdload", 16'h0002, 1'b0, 1'b1);
      applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      expectResult("hold0", 16'h0002, 1'b0, 1'b0);
      applyStimulus(16'h1234, 16'hABCD, 1'b0, 1'b0);
      expectResult("hold1", 16'h0002, 1'b0, 1'b0);
      applyStimulus('x, 'x, 1'bx, 1'b0);
      expectResult("hold2", 16'h0002, 1'b0, 1'b0);

      applyStimulus(16'hFFFE, 16'h0001, 1'b1, 1'b1);
      expectResult("resume", 16'h0000, 1'b1, 1'b1);
      applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0);
      expectResult("idle", 16'h0000, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
